// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D refill arbiter: FSM state, owner encoding and the
// default cache-line length.
package mem_arb_pkg;

  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    DONE = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The grant is combinational; the
// last-winner pointer moves only when the caller enables the grant.
module rr_arbiter2 import mem_arb_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic reqI,
  input  logic reqD,
  input  logic grantEn,
  output logic grantI,
  output logic grantD
);

  owner_t rrLast;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grantD = reqD && (!reqI || (rrLast == OWN_I));
    grantI = reqI && (!reqD || (rrLast == OWN_D));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrLast <= OWN_I;
    end else if (grantEn && grantD) begin
      rrLast <= OWN_D;
    end else if (grantEn && grantI) begin
      rrLast <= OWN_I;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one memory word port between ICache and DCache refills, running an
// optional DCache victim writeback burst ahead of each DCache refill burst.
module mem_refill_arbiter import mem_arb_pkg::*; #(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32,
  parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  output logic [WIDX_W-1:0] ic_widx,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic [WIDX_W-1:0] dc_widx,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output arbState_t         dbgState
);

  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);

  arbState_t         state;
  owner_t            owner;
  logic [WIDX_W-1:0] cnt;
  logic [ADDR_W-1:0] wbBase;
  logic [ADDR_W-1:0] rfBase;
  logic              grantEn;
  logic              grantI;
  logic              grantD;
  logic              inWb;
  logic              inRf;
  logic              busy;
  logic              rfXfer;
  logic [ADDR_W-1:0] lineAddr;

  assign grantEn = (state == IDLE);

  rr_arbiter2 uArb (
    .clk     (clk),
    .rst     (rst),
    .reqI    (ic_req),
    .reqD    (dc_req),
    .grantEn (grantEn),
    .grantI  (grantI),
    .grantD  (grantD)
  );

  // cnt wraps to 0 on the last word because LINE_WORDS is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWN_D;
      cnt    <= '0;
      wbBase <= '0;
      rfBase <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantI || grantD) begin
            owner  <= grantD ? OWN_D : OWN_I;
            cnt    <= '0;
            wbBase <= dc_wb_addr;
            rfBase <= grantD ? dc_addr : ic_addr;
            state  <= (grantD && dc_wb) ? WB : RF;
          end
        end
        WB: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= RF;
          end
        end
        RF: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below decodes registered state; only the per-word data and
  // rvalid strobes follow the memory handshake within the cycle.
  assign inWb     = (state == WB);
  assign inRf     = (state == RF);
  assign busy     = inWb || inRf;
  assign rfXfer   = inRf && mem_ready;
  assign lineAddr = (inWb ? wbBase : rfBase) + ADDR_W'({cnt, 2'b00});

  assign mem_req   = busy;
  assign mem_we    = inWb;
  assign mem_addr  = busy ? (lineAddr & ~ADDR_W'(3)) : '0;
  assign mem_wdata = inWb ? dc_wdata : '0;

  assign ic_rvalid = rfXfer && (owner == OWN_I);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_widx   = (busy && (owner == OWN_I)) ? cnt : '0;
  assign ic_done   = (state == DONE) && (owner == OWN_I);

  assign dc_rvalid = rfXfer && (owner == OWN_D);
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_widx   = (busy && (owner == OWN_D)) ? cnt : '0;
  assign dc_done   = (state == DONE) && (owner == OWN_D);

  assign dbgState = state;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: a transaction-level model of the
// expected memory traffic and completions, checked every cycle at negedge.
module tb_mem_refill_arbiter;

  localparam int LW    = 4;
  localparam int AW    = 32;
  localparam int WW    = 2;
  localparam int LIMIT = 400;

  typedef struct {
    logic          own;   // 0 = ICache, 1 = DCache
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [WW-1:0] idx;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [31:0]   ic_rdata;
  logic          ic_rvalid;
  logic [WW-1:0] ic_widx;
  logic          ic_done;
  logic          dc_req;
  logic          dc_wb;
  logic [AW-1:0] dc_wb_addr;
  logic [AW-1:0] dc_addr;
  logic [31:0]   dc_wdata;
  logic [WW-1:0] dc_widx;
  logic [31:0]   dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b1;
  logic [31:0]   mem_rdata;
  mem_arb_pkg::arbState_t dbgState;

  xfer_t         memExpQ[$];
  logic          doneExpQ[$];
  logic          doneLog[$];
  int            checks = 0;
  int            errors = 0;
  int            compCnt = 0;
  int            rdI = 0;
  int            rdD = 0;
  int            readyMode = 0;
  int            tick = 0;
  logic          modelLast = 1'b0;
  logic [AW-1:0] lastAddr = '0;

  mem_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_rdata   (ic_rdata),
    .ic_rvalid  (ic_rvalid),
    .ic_widx    (ic_widx),
    .ic_done    (ic_done),
    .dc_req     (dc_req),
    .dc_wb      (dc_wb),
    .dc_wb_addr (dc_wb_addr),
    .dc_addr    (dc_addr),
    .dc_wdata   (dc_wdata),
    .dc_widx    (dc_widx),
    .dc_rdata   (dc_rdata),
    .dc_rvalid  (dc_rvalid),
    .dc_done    (dc_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .dbgState   (dbgState)
  );

  // ---------------- clock / memory and victim-line responders ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_rdata = memWord(mem_addr);
  assign dc_wdata  = 32'hDA7A_0000 | 32'(dc_widx);

  // readyMode 1 gives the repeating ready pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    tick++;
    mem_ready = (readyMode == 0) || (tick % 3 == 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: expected traffic for one granted line ----------------
  task automatic expectLine(input logic own, input logic wb, input logic [AW-1:0] wbAddr,
                            input logic [AW-1:0] addr);
    xfer_t x;
    if (own && wb) begin
      for (int i = 0; i < LW; i++) begin
        x.own = 1'b1; x.we = 1'b1; x.addr = wbAddr + 32'(i * 4);
        x.wdata = 32'hDA7A_0000 | 32'(i); x.idx = WW'(i);
        memExpQ.push_back(x);
      end
    end
    for (int i = 0; i < LW; i++) begin
      x.own = own; x.we = 1'b0; x.addr = addr + 32'(i * 4);
      x.wdata = '0; x.idx = WW'(i);
      memExpQ.push_back(x);
    end
    doneExpQ.push_back(own);
    modelLast = own;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    xfer_t cur;
    logic  own;
    if (rst) begin
      if (mem_req) begin
        check("mem_align", 64'(mem_addr[1:0]), 64'd0);
        check("mem_pending", 64'(memExpQ.size() > 0), 64'd1);
        if (memExpQ.size() > 0) begin
          cur = memExpQ[0];
          check(mem_ready ? "mem_we" : "stall_we", 64'(mem_we), 64'(cur.we));
          check(mem_ready ? "mem_addr" : "stall_addr", 64'(mem_addr), 64'(cur.addr));
          if (!mem_ready) begin
            check("stall_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd0);
          end else begin
            void'(memExpQ.pop_front());
            compCnt++;
            lastAddr = mem_addr;
            if (cur.we) begin
              check("wb_wdata", 64'(mem_wdata), 64'(cur.wdata));
              check("wb_widx", 64'(dc_widx), 64'(cur.idx));
              check("wb_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd0);
            end else if (cur.own) begin
              check("dc_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd1);
              check("dc_rdata", 64'(dc_rdata), 64'(memWord(cur.addr)));
              check("dc_widx", 64'(dc_widx), 64'(cur.idx));
              check("ic_widx_idle", 64'(ic_widx), 64'd0);
              rdD++;
            end else begin
              check("ic_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd2);
              check("ic_rdata", 64'(ic_rdata), 64'(memWord(cur.addr)));
              check("ic_widx", 64'(ic_widx), 64'(cur.idx));
              check("dc_widx_idle", 64'(dc_widx), 64'd0);
              rdI++;
            end
          end
        end
      end else begin
        check("idle_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd0);
      end
      if (ic_done || dc_done) begin
        check("done_both", 64'(ic_done && dc_done), 64'd0);
        check("done_pending", 64'(doneExpQ.size() > 0), 64'd1);
        if (doneExpQ.size() > 0) begin
          own = doneExpQ.pop_front();
          check("done_owner", 64'(dc_done), 64'(own));
          check("done_words", 64'(own ? rdD : rdI), 64'(LW));
          if (own) rdD = 0; else rdI = 0;
          doneLog.push_back(own);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic runIc(input logic [AW-1:0] addr, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    ic_addr = addr;
    ic_req  = 1'b1;
    while (!got && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      got = ic_done;
      if (ic_rvalid) ic_addr = ~addr;  // base is latched at grant
    end
    check("ic_done_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    ic_req = 1'b0;
  endtask

  task automatic runDc(input logic wb, input logic [AW-1:0] wbAddr, input logic [AW-1:0] addr,
                       output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    dc_wb      = wb;
    dc_wb_addr = wbAddr;
    dc_addr    = addr;
    dc_req     = 1'b1;
    while (!got && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      got = dc_done;
      if (dc_rvalid) begin
        dc_addr    = ~addr;
        dc_wb_addr = ~wbAddr;
        dc_wb      = 1'b0;
      end
    end
    check("dc_done_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    dc_req = 1'b0;
  endtask

  // Both caches request in the same cycle; the model decides who goes first.
  task automatic tieTest(input logic [AW-1:0] iAddr, input logic wb, input logic [AW-1:0] wbAddr,
                         input logic [AW-1:0] dAddr);
    int latI;
    int latD;
    if (modelLast == 1'b0) begin
      expectLine(1'b1, wb, wbAddr, dAddr);
      expectLine(1'b0, 1'b0, '0, iAddr);
    end else begin
      expectLine(1'b0, 1'b0, '0, iAddr);
      expectLine(1'b1, wb, wbAddr, dAddr);
    end
    fork
      runIc(iAddr, latI);
      runDc(wb, wbAddr, dAddr, latD);
    join
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int base;
    int n;
    rst = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_wb = 1'b0; dc_wb_addr = '0; dc_addr = '0;

    #1;
    check("rst_mem", {30'd0, mem_req, mem_we, mem_addr}, 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_ic", 64'({ic_rdata, ic_rvalid, ic_widx, ic_done}), 64'd0);
    check("rst_dc", 64'({dc_rdata, dc_rvalid, dc_widx, dc_done}), 64'd0);
    check("rst_state", 64'(dbgState), 64'(mem_arb_pkg::IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Tie straight out of reset: DCache first, then ICache.
    base = doneLog.size();
    tieTest(32'h0000_0080, 1'b0, 32'h0, 32'h0000_0500);
    check("tie1_count", 64'(doneLog.size() - base), 64'd2);
    check("tie1_first", 64'(doneLog[base]), 64'd1);
    check("tie1_second", 64'(doneLog[base + 1]), 64'd0);

    // Single ICache refill: done on the 6th cycle after the request.
    expectLine(1'b0, 1'b0, '0, 32'h0000_0040);
    runIc(32'h0000_0040, lat);
    check("ic_latency", 64'(lat), 64'd6);
    check("ic_last_addr", 64'(lastAddr), 64'h4C);

    // DCache writeback + refill: done on the 10th cycle.
    expectLine(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200);
    runDc(1'b1, 32'h0000_0100, 32'h0000_0200, lat);
    check("dc_latency", 64'(lat), 64'd10);
    check("dc_last_addr", 64'(lastAddr), 64'h20C);

    // DCache won last, so the next tie goes to ICache.
    base = doneLog.size();
    tieTest(32'h0000_00C0, 1'b1, 32'h0000_0600, 32'h0000_0700);
    check("tie2_count", 64'(doneLog.size() - base), 64'd2);
    check("tie2_first", 64'(doneLog[base]), 64'd0);
    check("tie2_second", 64'(doneLog[base + 1]), 64'd1);

    // Refill under a stalling memory.
    readyMode = 1;
    expectLine(1'b0, 1'b0, '0, 32'h0000_0900);
    runIc(32'h0000_0900, lat);
    readyMode = 0;
    check("stall_last_addr", 64'(lastAddr), 64'h90C);

    // Line at the top of the address space.
    expectLine(1'b0, 1'b0, '0, 32'hFFFF_FFF0);
    runIc(32'hFFFF_FFF0, lat);
    check("wrap_last_addr", 64'(lastAddr), 64'hFFFF_FFFC);

    // Reset in the middle of a writeback, with word 2 on the bus.
    expectLine(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0400);
    dc_wb = 1'b1; dc_wb_addr = 32'h0000_0300; dc_addr = 32'h0000_0400; dc_req = 1'b1;
    base = compCnt;
    n = 0;
    while (compCnt - base < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midwb_reached", 64'(compCnt - base), 64'd2);
    @(posedge clk);
    #2;
    check("midwb_widx", 64'(dc_widx), 64'd2);
    check("midwb_addr", 64'(mem_addr), 64'h308);
    rst = 1'b0;
    #1;
    check("midrst_mem", {30'd0, mem_req, mem_we, mem_addr}, 64'd0);
    check("midrst_wdata", 64'(mem_wdata), 64'd0);
    check("midrst_ic", 64'({ic_rdata, ic_rvalid, ic_widx, ic_done}), 64'd0);
    check("midrst_dc", 64'({dc_rdata, dc_rvalid, dc_widx, dc_done}), 64'd0);
    check("midrst_state", 64'(dbgState), 64'(mem_arb_pkg::IDLE));
    memExpQ.delete();
    doneExpQ.delete();
    rdI = 0;
    rdD = 0;
    modelLast = 1'b0;
    dc_req = 1'b0;
    dc_wb  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // The abandoned request restarts cleanly from word 0.
    expectLine(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0400);
    runDc(1'b1, 32'h0000_0300, 32'h0000_0400, lat);
    check("restart_latency", 64'(lat), 64'd10);
    check("restart_last_addr", 64'(lastAddr), 64'h40C);

    repeat (3) @(posedge clk);
    #1;
    check("memq_drained", 64'(memExpQ.size()), 64'd0);
    check("doneq_drained", 64'(doneExpQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
